// File: rtl/vga_logo_scanner.sv
// -----------------------------------------------------------------------------
// vga_logo_scanner
//
// Raster scan generator and registered pixel-output stage for a VGA display
// (800x600@72 Hz timing by default, 50 MHz pixel clock). It drives raster
// coordinates x/y and a bouncing horizontal logo offset delt into external
// combinational logo painters. It then samples their merged hit result and
// produces registered colour and sync outputs.
//
// Ports:
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous active-low reset
//   scroll_en    in   1   enables the per-frame delt update (sampled at wrap)
//   hit          in   1   merged painter result for current x, y, delt
//   x            out  11  horizontal counter, 0..H_TOTAL-1
//   y            out  11  vertical counter, 0..V_TOTAL-1
//   delt         out  11  logo horizontal offset, 0..SCROLL_MAX
//   r, g, b      out  3   colour, {r,g,b} forms a 9-bit value
//   hsync        out  1   horizontal sync, active-high
//   vsync        out  1   vertical sync, active-high
//   frame_start  out  1   one-clock pulse while (0,0) is presented after a wrap
// -----------------------------------------------------------------------------
module vga_logo_scanner #(
  parameter int         H_ACTIVE    = 800,
  parameter int         H_FP        = 56,
  parameter int         H_SYNC      = 120,
  parameter int         H_BP        = 64,
  parameter int         V_ACTIVE    = 600,
  parameter int         V_FP        = 37,
  parameter int         V_SYNC      = 6,
  parameter int         V_BP        = 23,
  parameter int         SCROLL_STEP = 2,
  parameter int         SCROLL_MAX  = 250,
  parameter logic [8:0] FG_COLOR    = 9'h1FF,
  parameter logic [8:0] BG_COLOR    = 9'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scroll_en,
  input  logic        hit,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] delt,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int L_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int L_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] L_X_LAST     = 11'(L_H_TOTAL - 1);
  localparam logic [10:0] L_Y_LAST     = 11'(L_V_TOTAL - 1);
  localparam logic [10:0] L_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] L_V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] L_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] L_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] L_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] L_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] L_STEP11     = 11'(SCROLL_STEP);
  localparam logic [10:0] L_MAX11      = 11'(SCROLL_MAX);
  localparam logic [11:0] L_STEP12     = 12'(SCROLL_STEP);
  localparam logic [11:0] L_MAX12      = 12'(SCROLL_MAX);

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } scroll_state_t;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_frame_wrap;

  assign w_x_last     = (r_x == L_X_LAST);
  assign w_y_last     = (r_y == L_Y_LAST);
  assign w_frame_wrap = w_x_last && w_y_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= w_y_last ? 11'd0 : r_y + 11'd1;
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel output stage: one clock behind the counters, colour and sync aligned
  // ---------------------------------------------------------------------------
  logic       w_active;
  logic [8:0] w_rgb;
  logic       w_hsync;
  logic       w_vsync;
  logic [8:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_frame_start;

  assign w_active = (r_x < L_H_ACT) && (r_y < L_V_ACT);
  assign w_hsync  = (r_x >= L_HS_START) && (r_x < L_HS_END);
  assign w_vsync  = (r_y >= L_VS_START) && (r_y < L_VS_END);

  // Blanking forces black regardless of what the painters report.
  always_comb begin
    w_rgb = 9'h000;
    if (w_active) begin
      w_rgb = hit ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= w_rgb;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      // Registering the wrap makes the pulse coincide with (0,0) after a
      // wrap, and keeps it low for the first frame out of reset.
      r_frame_start <= w_frame_wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Scroll FSM: bounces delt between 0 and SCROLL_MAX, one step per frame
  // ---------------------------------------------------------------------------
  scroll_state_t r_state;
  scroll_state_t w_state_next;
  logic [10:0]   r_delt;
  logic [10:0]   w_delt_next;
  logic [11:0]   w_sum;
  logic          w_update;

  // 12-bit sum so delt + step cannot wrap before the comparison.
  assign w_sum    = {1'b0, r_delt} + L_STEP12;
  assign w_update = w_frame_wrap && scroll_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RIGHT;
      r_delt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_delt  <= w_delt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_update) begin
      case (r_state)
        RIGHT:   if (w_sum >= L_MAX12) w_state_next = LEFT;
        LEFT:    if ({1'b0, r_delt} <= L_STEP12) w_state_next = RIGHT;
        default: w_state_next = RIGHT;
      endcase
    end
  end

  always_comb begin
    w_delt_next = r_delt;
    if (w_update) begin
      case (r_state)
        RIGHT:   w_delt_next = (w_sum >= L_MAX12) ? L_MAX11 : w_sum[10:0];
        LEFT:    w_delt_next = ({1'b0, r_delt} <= L_STEP12) ? 11'd0 : r_delt - L_STEP11;
        default: w_delt_next = r_delt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x           = r_x;
  assign y           = r_y;
  assign delt        = r_delt;
  assign {r, g, b}   = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_logo_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_logo_scanner
//
// Self-checking bench for vga_logo_scanner. The DUT is built with a reduced
// raster (30 x 17) so whole frames fit in a short run. The bench covers:
//   - reset state, including asynchronous assertion mid-frame
//   - a table of single-pixel hit/sync vectors at region boundaries
//   - a full delt bounce sequence and a scroll_en hold with off-wrap toggles
//   - frame_start timing after a mid-frame reset
//   - a randomized run checked against a coordinate/scroll model
// -----------------------------------------------------------------------------
module tb_vga_logo_scanner;

  localparam int         HA = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int         VA = 10, VFP = 2, VS = 3, VBP = 2;
  localparam int         HT = HA + HFP + HS + HBP;   // 30
  localparam int         VT = VA + VFP + VS + VBP;   // 17
  localparam int         FRAME = HT * VT;            // 510
  localparam int         STEP = 3;
  localparam int         SMAX = 20;
  localparam logic [8:0] FG = 9'h1FF;
  localparam logic [8:0] BG = 9'h055;
  localparam int         RAND_CYC = 20 * FRAME;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scroll_en = 1'b0;
  logic        hit = 1'b0;
  logic [10:0] x, y, delt;
  logic [2:0]  r, g, b;
  logic        hsync, vsync, frame_start;
  logic [8:0]  rgb;

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  vga_logo_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SCROLL_STEP(STEP), .SCROLL_MAX(SMAX),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .hit(hit),
    .x(x), .y(y), .delt(delt), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with release between edges; on return x is still 0.
  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  function automatic logic [8:0] exp_rgb(input int px, input int py, input bit ph);
    if (px < HA && py < VA) return ph ? FG : BG;
    return 9'h000;
  endfunction

  typedef struct {
    int         tx;
    int         ty;
    bit         hit;
    logic [8:0] e_rgb;
    bit         e_hs;
    bit         e_vs;
  } vec_t;

  vec_t vecs[14];
  int   bounce[15];

  // Watchdog: the whole run is far below this.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int mx, my, px, py;
    bit ph;
    int m_delt;
    bit m_right;

    vecs[0]  = '{10, 5, 1'b1, 9'h1FF, 1'b0, 1'b0};
    vecs[1]  = '{10, 5, 1'b0, 9'h055, 1'b0, 1'b0};
    vecs[2]  = '{15, 9, 1'b1, 9'h1FF, 1'b0, 1'b0};
    vecs[3]  = '{16, 9, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[4]  = '{15, 10, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[5]  = '{19, 0, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[6]  = '{20, 0, 1'b1, 9'h000, 1'b1, 1'b0};
    vecs[7]  = '{25, 0, 1'b0, 9'h000, 1'b1, 1'b0};
    vecs[8]  = '{26, 0, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[9]  = '{0, 12, 1'b0, 9'h000, 1'b0, 1'b1};
    vecs[10] = '{5, 11, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[11] = '{29, 14, 1'b1, 9'h000, 1'b0, 1'b1};
    vecs[12] = '{0, 15, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[13] = '{0, 0, 1'b1, 9'h1FF, 1'b0, 1'b0};

    bounce = '{3, 6, 9, 12, 15, 18, 20, 17, 14, 11, 8, 5, 2, 0, 3};

    // ---------------- reset state, with hit and scroll_en driven high -------
    hit = 1'b1;
    scroll_en = 1'b1;
    step(3);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_delt", 32'(delt), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hs", 32'(hsync), 0);
    chk("rst_vs", 32'(vsync), 0);
    chk("rst_fs", 32'(frame_start), 0);
    $display("reset state checked");
    hit = 1'b0;
    scroll_en = 1'b0;

    // ---------------- table of single-pixel vectors ------------------------
    foreach (vecs[i]) begin
      do_reset();
      step(vecs[i].ty * HT + vecs[i].tx);
      chk("vec_pos", 32'({y, x}), 32'({11'(vecs[i].ty), 11'(vecs[i].tx)}));
      hit = vecs[i].hit;
      step(1);
      hit = 1'b0;
      chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].e_rgb));
      chk($sformatf("vec%0d_hs", i), 32'(hsync), 32'(vecs[i].e_hs));
      chk($sformatf("vec%0d_vs", i), 32'(vsync), 32'(vecs[i].e_vs));
      $display("vec %0d at (%0d,%0d) hit=%0b rgb=%03h hs=%0b vs=%0b",
               i, vecs[i].tx, vecs[i].ty, vecs[i].hit, rgb, hsync, vsync);
    end

    // ---------------- full bounce with scroll_en held high -----------------
    do_reset();
    scroll_en = 1'b1;
    foreach (bounce[i]) begin
      step(FRAME);
      chk($sformatf("bounce%0d_delt", i), 32'(delt), 32'(bounce[i]));
      chk($sformatf("bounce%0d_fs", i), 32'(frame_start), 1);
      chk($sformatf("bounce%0d_xy", i), 32'({y, x}), 0);
      $display("frame %0d delt=%0d", i + 1, delt);
    end

    // ---------------- hold: scroll_en pulsed only away from the wrap -------
    scroll_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      step(200);
      scroll_en = 1'b1;
      step(10);
      scroll_en = 1'b0;
      step(FRAME - 210);
      chk($sformatf("hold%0d_delt", f), 32'(delt), 3);
      $display("hold frame %0d delt=%0d", f, delt);
    end

    // ---------------- asynchronous reset mid-frame -------------------------
    step(8 * HT + 7);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 0);
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_delt", 32'(delt), 0);
    chk("mid_rst_rgb", 32'(rgb), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    while (cnt < FRAME + 20) begin
      step(1);
      cnt++;
      if (frame_start === 1'b1) break;
    end
    chk("mid_rst_first_fs_edges", 32'(cnt), 32'(FRAME));
    chk("mid_rst_delt_after", 32'(delt), 0);
    $display("first frame_start after mid-frame reset at edge %0d", cnt);

    // ---------------- randomized run against reference model ---------------
    do_reset();
    m_delt  = 0;
    m_right = 1'b1;
    px = 0;
    py = 0;
    ph = 1'b0;
    for (int n = 0; n < RAND_CYC; n++) begin
      mx = n % HT;
      my = (n / HT) % VT;
      chk("rnd_x", 32'(x), 32'(mx));
      chk("rnd_y", 32'(y), 32'(my));
      chk("rnd_delt", 32'(delt), 32'(m_delt));
      chk("rnd_fs", 32'(frame_start), 32'(n > 0 && mx == 0 && my == 0));
      if (n == 0) begin
        chk("rnd_rgb0", 32'(rgb), 0);
      end else begin
        chk("rnd_rgb", 32'(rgb), 32'(exp_rgb(px, py, ph)));
        chk("rnd_hs", 32'(hsync), 32'(px >= HA + HFP && px < HA + HFP + HS));
        chk("rnd_vs", 32'(vsync), 32'(py >= VA + VFP && py < VA + VFP + VS));
      end
      hit       = 1'($urandom_range(0, 1));
      scroll_en = ($urandom_range(0, 3) != 0);
      if (mx == HT - 1 && my == VT - 1) begin
        if (scroll_en) begin
          if (m_right) begin
            if (m_delt + STEP >= SMAX) begin m_delt = SMAX; m_right = 1'b0; end
            else m_delt = m_delt + STEP;
          end else begin
            if (m_delt <= STEP) begin m_delt = 0; m_right = 1'b1; end
            else m_delt = m_delt - STEP;
          end
        end
        $display("random frame %0d end scroll_en=%0b model delt=%0d", n / FRAME, scroll_en, m_delt);
      end
      px = mx;
      py = my;
      ph = hit;
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
